// File: rtl/serial_sub.sv
// Bit-serial a - b - bin, LSB first; done pulses the cycle after the WIDTH-th RUN edge (WIDTH+1 edges from accept).
// No backpressure: start is ignored while busy, and results hold until the next completion.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-2:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] diff_q;
    logic             br_q;
    logic             br_d;
    logic             bout_q;
    logic             d_bit;
    logic [CW-1:0]    cnt_q;

    // One full-subtractor slice; the result register is one bit short because
    // the final bit lands directly in diff on the completion edge.
    assign d_bit = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    assign br_d  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    assign r_d   = {d_bit, r_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    br_q   <= br_d;
                    r_q    <= r_d[WIDTH-1:1];
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        diff_q  <= r_d;
                        bout_q  <= br_d;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
Bit-serial subtractor computing a − b − bin one bit per clock, LSB first, with a single borrow flip-flop. It is the inverse operation of the team's combinational ripple adder, in sequential area-saving form. It sits beside the ripple adder in the arithmetic library. It reuses the same 4-bit operand and borrow/carry conventions, so the same vectors check both blocks.

Parameters:
WIDTH, 4, operand and result width in bits (≥2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled on clk rising edge
a  input  WIDTH  minuend; sampled only when start is accepted
b  input  WIDTH  subtrahend; sampled only when start is accepted
bin  input  1  borrow-in; sampled only when start is accepted
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse: diff/bout just updated
diff  output  WIDTH  result a − b − bin mod 2^WIDTH
bout  output  1  borrow-out; 1 when a < b + bin (unsigned)

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, diff=0, bout=0, internal shift regs/counter/borrow=0. Takes effect immediately, no clock needed.
- States: IDLE, RUN, DONE. All outputs registered or decoded from state only; no combinational input-to-output path.
- IDLE/DONE + start=1 at edge k:
  - latch a→a_sh, b→b_sh, bin→br; cnt=0; state→RUN.
  - Edge k is the accept edge.
- RUN, each edge:
  - d = a_sh[0]^b_sh[0]^br;
  - br ← (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&br);
  - a_sh, b_sh shift right;
  - d shifts into the MSB of the internal result reg r;
  - cnt++.
- On the WIDTH-th RUN edge (edge k+WIDTH): diff←final r (including this edge's d), bout←final br, state→DONE.
- DONE: done=1 for exactly one cycle (the cycle after edge k+WIDTH). Next edge → IDLE, unless start=1, in which case the new operation is accepted (back-to-back, no idle gap).
- busy = (state==RUN). It is high from edge k to edge k+WIDTH, i.e. WIDTH cycles.
- Latency: start accepted at edge k → done high during the cycle after edge k+WIDTH. For WIDTH=4, that is 5 edges from accept to done edge.
- start while RUN: ignored; latched operands unaffected; inputs may change freely during RUN.
- diff/bout hold the previous result during RUN. They change only at the completion edge and hold until the next completion or reset.
- Reset mid-RUN: operation aborted, no done pulse, outputs to 0.
- Width rule: all arithmetic is mod 2^WIDTH; bout is the only overflow indication. No sign interpretation inside the block.

Test Plan:
- Reset then a=1101,b=0011,bin=0,start 1 cycle → busy 4 cycles, done pulse 1 cycle, diff=1010, bout=0.
- a=1000,b=1010,bin=1 → diff=1101, bout=1. Then a=0111,b=1011,bin=0 → diff=1100, bout=1.
- a=0111,b=0010,bin=1 → diff=0100, bout=0. Edge case a=0000,b=0000,bin=1 → diff=1111, bout=1.
- start held high continuously with a=1101,b=0011 → result 1010 each time; done pulses every 5 cycles; busy low only in DONE cycles. Changing a/b/start during RUN does not alter the in-flight result.
- Assert rst 2 cycles into RUN → busy/done/diff/bout=0 immediately, no done pulse. Next start after release computes correctly (e.g. 1101−0011 → 1010).
- Randomised sweep of all 512 (a,b,bin) combos for WIDTH=4, compared against (a−b−bin) mod 16 and the borrow flag. Repeat the sweep at WIDTH=8 using 1000 random vectors.
